// File: rtl/implication_window_checker.sv
// rtl/implication_window_checker.sv - multi-channel "ante |-> ##[MIN_DLY:MAX_DLY] cons" checker
//
// Every cycle with en && ante[c] launches an independent attempt on channel c.
// An attempt passes when cons[c] is seen at an age within [MIN_DLY, MAX_DLY].
// It fails when it reaches age MAX_DLY without cons[c].
// Pass/fail pulses and saturating counters are reported per channel, and the
// first failure since reset/clr is recorded.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   en                allows sampled ante to launch attempts
//   clr               synchronous clear of counters and first-fail record
//   ante, cons        per-channel antecedent / consequent
//   pass_o, fail_o    per-channel single-cycle result pulses
//   pass_cnt/fail_cnt per-channel saturating counters, channel c at [c*CNT_W +: CNT_W]
//   any_fail          sticky failure flag
//   first_fail_ch     lowest channel failing at the first failure edge
//   first_fail_time   cycle counter value at the first failure edge
module implication_window_checker #(
  parameter  int N_CH    = 4,
  parameter  int MIN_DLY = 4,
  parameter  int MAX_DLY = 4,
  parameter  int CNT_W   = 16,
  parameter  int TIME_W  = 32,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [N_CH-1:0]       ante,
  input  logic [N_CH-1:0]       cons,
  output logic [N_CH-1:0]       pass_o,
  output logic [N_CH-1:0]       fail_o,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic                  any_fail,
  output logic [CH_W-1:0]       first_fail_ch,
  output logic [TIME_W-1:0]     first_fail_time
);

  // pend[c][k]: an attempt on channel c will be age k at the next edge.
  logic [N_CH-1:0][MAX_DLY:1] pend, pend_nxt;
  // Up to MAX_DLY pending attempts plus a same-edge launch may pass together.
  logic [N_CH-1:0][5:0]       npass;
  logic [N_CH-1:0]            launch, pass_now, fail_now;
  logic [N_CH-1:0][CNT_W-1:0] pcnt, fcnt;
  logic [TIME_W-1:0]          tcnt;
  logic [CH_W-1:0]            low_ch;

  assign launch   = {N_CH{en}} & ante;
  assign pass_cnt = pcnt;
  assign fail_cnt = fcnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [5:0]       b);
    logic [CNT_W+6:0] s;
    s = {7'd0, a} + {{(CNT_W+1){1'b0}}, b};
    if (s > {7'd0, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    pend_nxt = '0;
    npass    = '0;
    pass_now = '0;
    fail_now = '0;
    low_ch   = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 1; k <= MAX_DLY; k++) begin
        if (k >= MIN_DLY && pend[c][k] && cons[c]) npass[c] = npass[c] + 6'd1;
      end
      // Age k-1 survives into age k unless it just passed.
      for (int k = 2; k <= MAX_DLY; k++) begin
        pend_nxt[c][k] = pend[c][k-1] && !((k - 1) >= MIN_DLY && cons[c]);
      end
      // A fresh attempt with a zero minimum delay can be satisfied at its own edge.
      if (MIN_DLY == 0 && launch[c] && cons[c]) npass[c] = npass[c] + 6'd1;
      pend_nxt[c][1] = launch[c] && !(MIN_DLY == 0 && cons[c]);
      // Only one attempt can occupy the oldest slot, so at most one fail per edge.
      fail_now[c] = pend[c][MAX_DLY] && !cons[c];
      pass_now[c] = |npass[c];
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (fail_now[c]) low_ch = CH_W'(c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend            <= '0;
      tcnt            <= '0;
      pass_o          <= '0;
      fail_o          <= '0;
      pcnt            <= '0;
      fcnt            <= '0;
      any_fail        <= 1'b0;
      first_fail_ch   <= '0;
      first_fail_time <= '0;
    end else begin
      pend   <= pend_nxt;
      tcnt   <= tcnt + TIME_W'(1);
      pass_o <= pass_now;
      fail_o <= fail_now;
      if (clr) begin
        // Results at the clear edge still pulse but are neither counted nor recorded.
        pcnt            <= '0;
        fcnt            <= '0;
        any_fail        <= 1'b0;
        first_fail_ch   <= '0;
        first_fail_time <= '0;
      end else begin
        for (int c = 0; c < N_CH; c++) begin
          pcnt[c] <= sat_add(pcnt[c], npass[c]);
          fcnt[c] <= sat_add(fcnt[c], {5'd0, fail_now[c]});
        end
        if (!any_fail && |fail_now) begin
          any_fail        <= 1'b1;
          first_fail_ch   <= low_ch;
          first_fail_time <= tcnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_implication_window_checker.sv
// tb/tb_implication_window_checker.sv - randomized bench with queue-based reference model
module tb_implication_window_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] ante = '0;
  logic [3:0] cons = '0;

  logic [3:0]  a_po, a_fo, b_po, b_fo, c_po, c_fo;
  logic [63:0] a_pc, a_fc;
  logic [7:0]  b_pc, b_fc;
  logic [15:0] c_pc, c_fc;
  logic        a_af, b_af, c_af;
  logic [1:0]  a_fch, b_fch, c_fch;
  logic [31:0] a_ft, b_ft;
  logic [7:0]  c_ft;

  always #5 clk = ~clk;

  implication_window_checker #(.N_CH(4), .MIN_DLY(4), .MAX_DLY(4), .CNT_W(16), .TIME_W(32)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ante(ante), .cons(cons),
    .pass_o(a_po), .fail_o(a_fo), .pass_cnt(a_pc), .fail_cnt(a_fc),
    .any_fail(a_af), .first_fail_ch(a_fch), .first_fail_time(a_ft));

  implication_window_checker #(.N_CH(4), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(2), .TIME_W(32)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ante(ante), .cons(cons),
    .pass_o(b_po), .fail_o(b_fo), .pass_cnt(b_pc), .fail_cnt(b_fc),
    .any_fail(b_af), .first_fail_ch(b_fch), .first_fail_time(b_ft));

  implication_window_checker #(.N_CH(4), .MIN_DLY(0), .MAX_DLY(3), .CNT_W(4), .TIME_W(8)) dut_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ante(ante), .cons(cons),
    .pass_o(c_po), .fail_o(c_fo), .pass_cnt(c_pc), .fail_cnt(c_fc),
    .any_fail(c_af), .first_fail_ch(c_fch), .first_fail_time(c_ft));

  int mn[3] = '{4, 2, 0};
  int mx[3] = '{4, 4, 3};
  int cw[3] = '{16, 2, 4};
  int tw[3] = '{32, 32, 8};

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Reference model: each pending attempt is just its launch edge number.
  int         q[3][4][$];
  int         mt;
  logic [3:0] e_po[3];
  logic [3:0] e_fo[3];
  int         e_pc[3][4];
  int         e_fc[3][4];
  logic       e_af[3];
  int         e_fch[3];
  longint     e_ft[3];

  always @(posedge clk or posedge rst) begin
    int np, age, lim, low;
    int nq[$];
    if (rst) begin
      mt = 0;
      for (int i = 0; i < 3; i++) begin
        e_po[i] = '0; e_fo[i] = '0; e_af[i] = 1'b0; e_fch[i] = 0; e_ft[i] = 0;
        for (int c = 0; c < 4; c++) begin
          q[i][c].delete(); e_pc[i][c] = 0; e_fc[i][c] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        lim = (1 << cw[i]) - 1;
        low = -1;
        for (int c = 0; c < 4; c++) begin
          np = 0;
          e_fo[i][c] = 1'b0;
          nq.delete();
          foreach (q[i][c][k]) begin
            age = mt - q[i][c][k];
            if (age >= mn[i] && cons[c]) np++;
            else if (age == mx[i]) e_fo[i][c] = 1'b1;
            else nq.push_back(q[i][c][k]);
          end
          if (en && ante[c]) begin
            if (mn[i] == 0 && cons[c]) np++;
            else nq.push_back(mt);
          end
          q[i][c] = nq;
          e_po[i][c] = (np > 0);
          if (e_fo[i][c] && low < 0) low = c;
          if (clr) begin
            e_pc[i][c] = 0; e_fc[i][c] = 0;
          end else begin
            e_pc[i][c] = (e_pc[i][c] + np > lim) ? lim : e_pc[i][c] + np;
            e_fc[i][c] = (e_fc[i][c] + int'(e_fo[i][c]) > lim) ? lim : e_fc[i][c] + int'(e_fo[i][c]);
          end
        end
        if (clr) begin
          e_af[i] = 1'b0; e_fch[i] = 0; e_ft[i] = 0;
        end else if (!e_af[i] && low >= 0) begin
          e_af[i] = 1'b1; e_fch[i] = low;
          e_ft[i] = longint'(mt) & ((longint'(1) << tw[i]) - 1);
        end
      end
      mt++;
    end
  end

  task automatic cmp(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic [3:0] po, input logic [3:0] fo,
                          input logic [63:0] pc, input logic [63:0] fc, input logic af,
                          input logic [1:0] fch, input logic [31:0] ft);
    longint m;
    m = (longint'(1) << cw[i]) - 1;
    cmp($sformatf("i%0d pass_o", i), longint'(po), longint'(e_po[i]));
    cmp($sformatf("i%0d fail_o", i), longint'(fo), longint'(e_fo[i]));
    for (int c = 0; c < 4; c++) begin
      cmp($sformatf("i%0d pass_cnt[%0d]", i, c), longint'(pc >> (c * cw[i])) & m, longint'(e_pc[i][c]));
      cmp($sformatf("i%0d fail_cnt[%0d]", i, c), longint'(fc >> (c * cw[i])) & m, longint'(e_fc[i][c]));
    end
    cmp($sformatf("i%0d any_fail", i), longint'(af), longint'(e_af[i]));
    cmp($sformatf("i%0d first_fail_ch", i), longint'(fch), longint'(e_fch[i]));
    cmp($sformatf("i%0d first_fail_time", i), longint'(ft), e_ft[i]);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk_inst(0, a_po, a_fo, a_pc, a_fc, a_af, a_fch, a_ft);
      chk_inst(1, b_po, b_fo, 64'(b_pc), 64'(b_fc), b_af, b_fch, b_ft);
      chk_inst(2, c_po, c_fo, 64'(c_pc), 64'(c_fc), c_af, c_fch, 32'(c_ft));
    end
  end

  task automatic tick(input logic [3:0] a, input logic [3:0] c);
    ante = a;
    cons = c;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    ante = '0; cons = '0; en = 1'b1; clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    run_cmp = 1'b1;
    cmp("reset pass_o", longint'(a_po), 0);
    cmp("reset pass_cnt", longint'(a_pc), 0);
    cmp("reset any_fail", longint'(a_af), 0);
    cmp("reset first_fail_time", longint'(a_ft), 0);

    // ante[0] at edge 1, cons[0] at edge 5
    tick(4'd0, 4'd0); tick(4'd1, 4'd0);
    repeat (3) tick(4'd0, 4'd0);
    tick(4'd0, 4'd1);
    cmp("t1 pass_o", longint'(a_po), 1);
    cmp("t1 pass_cnt0", longint'(a_pc[15:0]), 1);
    cmp("t1 fail_cnt0", longint'(a_fc[15:0]), 0);

    // cons[0] only at edge 6
    do_reset();
    tick(4'd0, 4'd0); tick(4'd1, 4'd0);
    repeat (4) tick(4'd0, 4'd0);
    cmp("t2 fail_o", longint'(a_fo), 1);
    cmp("t2 any_fail", longint'(a_af), 1);
    cmp("t2 first_fail_time", longint'(a_ft), 5);
    tick(4'd0, 4'd1);
    cmp("t2 late cons no pass", longint'(a_pc[15:0]), 0);

    // overlapping attempts, one cons
    do_reset();
    tick(4'd0, 4'd0); tick(4'd1, 4'd0); tick(4'd1, 4'd0);
    tick(4'd0, 4'd0); tick(4'd0, 4'd0);
    tick(4'd0, 4'd1);
    cmp("t3 pass_o", longint'(a_po), 1);
    tick(4'd0, 4'd0);
    cmp("t3 fail_o", longint'(a_fo), 1);
    cmp("t3 pass_cnt0", longint'(a_pc[15:0]), 1);
    cmp("t3 fail_cnt0", longint'(a_fc[15:0]), 1);

    // MIN=2: two attempts pass on one cons edge
    do_reset();
    tick(4'd0, 4'd0); tick(4'd2, 4'd0); tick(4'd2, 4'd0);
    tick(4'd0, 4'd0); tick(4'd0, 4'd2);
    cmp("t4 pass_o", longint'(b_po), 2);
    cmp("t4 pass_cnt1", longint'(b_pc[3:2]), 2);
    tick(4'd0, 4'd0);
    cmp("t4 single pulse", longint'(b_po), 0);

    // two channels fail together, then clr
    do_reset();
    tick(4'd0, 4'd0); tick(4'b1010, 4'd0);
    repeat (4) tick(4'd0, 4'd0);
    cmp("t5 fail_o", longint'(a_fo), 10);
    cmp("t5 first_fail_ch", longint'(a_fch), 1);
    cmp("t5 fail_cnt3", longint'(a_fc[63:48]), 1);
    clr = 1'b1;
    tick(4'd0, 4'd0);
    clr = 1'b0;
    cmp("t5 clr any_fail", longint'(a_af), 0);
    cmp("t5 clr fail_cnt", longint'(a_fc), 0);
    cmp("t5 clr first_fail_ch", longint'(a_fch), 0);

    // reset in the middle of an attempt
    do_reset();
    tick(4'd0, 4'd0); tick(4'd1, 4'd0); tick(4'd0, 4'd0);
    rst = 1'b1;
    tick(4'd0, 4'd0);
    rst = 1'b0;
    repeat (6) tick(4'd0, 4'd0);
    cmp("t6 no fail after rst", longint'(a_af), 0);
    cmp("t6 fail_cnt0", longint'(a_fc[15:0]), 0);

    // saturation: five passes on a 2-bit counter
    do_reset();
    repeat (5) tick(4'd1, 4'd1);
    repeat (3) tick(4'd0, 4'd1);
    cmp("t6 sat pass_cnt0", longint'(b_pc[1:0]), 3);
    cmp("t6 min0 pass_cnt0", longint'(c_pc[3:0]), 5);

    // randomized phase
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      if (n % 1000 < 500)
        tick(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      else
        tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) | $urandom_range(0, 15)));
      rst = 1'b0;
    end
    clr = 1'b0;
    repeat (6) tick(4'd0, 4'd0);
    run_cmp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
